// File: rtl/three_bit_down_counter.sv
// Loadable down counter with terminal-count strobe and optional auto-reload; optional DC_TC_COUNT_EN adds a saturating dc_tc pulse counter.
// Latency: a load shows on dc_out one cycle after acceptance; dc_tc appears the cycle after the terminal (zero, enabled) cycle.
// Backpressure: dc_load_ready is high only in IDLE; a requester holds dc_load_valid until it is accepted.
module three_bit_down_counter #(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] RELOAD_VAL = {WIDTH{1'b1}}
) (
    input  logic             dc_clk,
    input  logic             dc_rst_n,
    input  logic             dc_load_valid,
    input  logic [WIDTH-1:0] dc_load_val,
    output logic             dc_load_ready,
    input  logic             dc_en,
    input  logic             dc_auto_reload,
    input  logic             dc_clr,
    output logic [WIDTH-1:0] dc_out,
`ifdef DC_TC_COUNT_EN
    output logic [7:0]       dc_tc_count,
`endif
    output logic             dc_tc,
    output logic             dc_busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ready_q;
    logic             busy_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        tc_d    = 1'b0;
        if (dc_clr) begin
            // Abort beats both a pending load and a terminal event.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dc_load_valid) begin
                        out_d   = dc_load_val;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (dc_en) begin
                        if (out_q != '0) begin
                            out_d = out_q - WIDTH'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (dc_auto_reload) begin
                                out_d = RELOAD_VAL;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge dc_clk or negedge dc_rst_n) begin
        if (!dc_rst_n) begin
            state_q <= S_IDLE;
            out_q   <= RELOAD_VAL;
            tc_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tc_q    <= tc_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_COUNT);
        end
    end

    assign dc_out        = out_q;
    assign dc_tc         = tc_q;
    assign dc_load_ready = ready_q;
    assign dc_busy       = busy_q;

`ifdef DC_TC_COUNT_EN
    logic [7:0] tc_cnt_q, tc_cnt_d;

    // Counted on tc_d so the count steps in the same cycle dc_tc is seen.
    always_comb begin
        tc_cnt_d = tc_cnt_q;
        if (dc_clr) begin
            tc_cnt_d = 8'd0;
        end else if (tc_d && (tc_cnt_q != 8'hFF)) begin
            tc_cnt_d = tc_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge dc_clk or negedge dc_rst_n) begin
        if (!dc_rst_n) begin
            tc_cnt_q <= 8'd0;
        end else begin
            tc_cnt_q <= tc_cnt_d;
        end
    end

    assign dc_tc_count = tc_cnt_q;
`endif

endmodule
